// File: rtl/spi_xfer_if.sv
// Bus bundle for spi_xfer: configuration, transfer handshake, status and SPI pins.
// The master side drives configuration and serial input; the slave side is the controller.
interface spi_xfer_if;
  logic [2:0] clk_div;
  logic       irq_en;
  logic [1:0] cs_sel;
  logic [1:0] mode;
  logic [7:0] tx_data;
  logic       start;
  logic       irq_clr;
  logic       miso;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       irq;
  logic       sclk;
  logic       mosi;
  logic [3:0] cs_n;

  modport master (
    output clk_div, irq_en, cs_sel, mode, tx_data, start, irq_clr, miso,
    input  busy, done, rx_data, irq, sclk, mosi, cs_n
  );

  modport slave (
    input  clk_div, irq_en, cs_sel, mode, tx_data, start, irq_clr, miso,
    output busy, done, rx_data, irq, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_xfer.sv
// Single-byte SPI master: SETUP, 16 SCLK half-periods, HOLD, one-cycle DONE.
// All outputs are registered; configuration is captured when start is accepted.
module spi_xfer (
  input  logic      clk,
  input  logic      rst,
  spi_xfer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] hp_q, hp_d;
  logic [2:0] div_q, div_d;
  logic       irq_en_q, irq_en_d;
  logic       cpha_q, cpha_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_q, rx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       irq_q, irq_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic [3:0] cs_n_q, cs_n_d;

  logic       tick;
  logic       edge_en;
  logic [3:0] edge_idx;
  logic       irq_set;

  // Reload value H-1; the cast keeps clk_div=7 at 127 rather than wrapping.
  function automatic logic [6:0] half_m1(input logic [2:0] d);
    return 7'((8'd1 << d) - 8'd1);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hp_d     = hp_q;
    div_d    = div_q;
    irq_en_d = irq_en_q;
    cpha_d   = cpha_q;
    tx_d     = tx_q;
    rx_sh_d  = rx_sh_q;
    rx_d     = rx_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    edge_en  = 1'b0;
    edge_idx = 4'd0;
    irq_set  = 1'b0;
    tick     = (cnt_q == 7'd0);

    case (state_q)
      IDLE: begin
        sclk_d = bus.mode[1];
        if (bus.start) begin
          state_d  = SETUP;
          div_d    = bus.clk_div;
          irq_en_d = bus.irq_en;
          cpha_d   = bus.mode[0];
          tx_d     = bus.tx_data;
          cnt_d    = half_m1(bus.clk_div);
          hp_d     = 4'd0;
          busy_d   = 1'b1;
          cs_n_d   = ~(4'b0001 << bus.cs_sel);
          mosi_d   = bus.mode[0] ? 1'b0 : bus.tx_data[7];
        end
      end
      SETUP: begin
        if (tick) begin
          state_d  = XFER;
          cnt_d    = half_m1(div_q);
          hp_d     = 4'd0;
          edge_en  = 1'b1;
          edge_idx = 4'd0;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      XFER: begin
        if (!tick) begin
          cnt_d = cnt_q - 7'd1;
        end else if (hp_q == 4'd15) begin
          state_d = HOLD;
          cnt_d   = half_m1(div_q);
        end else begin
          cnt_d    = half_m1(div_q);
          hp_d     = hp_q + 4'd1;
          edge_en  = 1'b1;
          edge_idx = hp_q + 4'd1;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cs_n_d  = 4'hF;
          rx_d    = rx_sh_q;
          irq_set = irq_en_q;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        mosi_d  = 1'b0;
        sclk_d  = bus.mode[1];
        irq_set = irq_en_q;
      end
      default: state_d = IDLE;
    endcase

    // Even edge index is a leading edge; sampling happens on leading edges when CPHA=0.
    if (edge_en) begin
      sclk_d = ~sclk_q;
      if (edge_idx[0] == cpha_q) begin
        rx_sh_d = {rx_sh_q[6:0], bus.miso};
      end else if (!(!cpha_q && edge_idx == 4'd15)) begin
        mosi_d = cpha_q ? tx_q[7] : tx_q[6];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end

    // Setting is held through the DONE cycle so a clear landing there cannot win.
    if (irq_set)          irq_d = 1'b1;
    else if (bus.irq_clr) irq_d = 1'b0;
    else                  irq_d = irq_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      hp_q     <= 4'd0;
      div_q    <= 3'd0;
      irq_en_q <= 1'b0;
      cpha_q   <= 1'b0;
      tx_q     <= 8'h00;
      rx_sh_q  <= 8'h00;
      rx_q     <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 4'hF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      div_q    <= div_d;
      irq_en_q <= irq_en_d;
      cpha_q   <= cpha_d;
      tx_q     <= tx_d;
      rx_sh_q  <= rx_sh_d;
      rx_q     <= rx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;
  assign bus.irq     = irq_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_xfer.sv
// Bench for spi_xfer: directed and random transfers predicted from the transfer
// timeline (18H+1 cycles) and the byte-level SPI behaviour.
module tb_spi_xfer;

  logic clk = 1'b0;
  logic rst;
  logic loop_en;
  logic miso_drv;

  int         checks = 0;
  int         errors = 0;
  int         cur_cyc = 0;
  logic [7:0] prev_rx;
  logic       irq_cur;

  spi_xfer_if bus ();

  spi_xfer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.miso = loop_en ? bus.mosi : miso_drv;

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got %b exp %b", tag, cur_cyc, got, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got %h exp %h", tag, cur_cyc, got, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got %h exp %h", tag, cur_cyc, got, exp);
    end
  endtask

  // One transfer with start accepted at cycle 0; every cycle is compared against the timeline.
  task automatic run_xfer(input logic [2:0] div, input logic [1:0] md, input logic [1:0] cs,
                          input logic [7:0] tx, input logic ien, input logic lp,
                          input logic [7:0] pat, input logic disturb, input logic clr_at_done);
    int         h, last, n_exp, ecnt;
    logic [7:0] mcap, pat_sh, exp_rx;
    logic [3:0] exp_cs;
    logic       psclk, samp_edge, exp_sclk;
    h      = 1 << div;
    last   = 18 * h + 1;
    exp_rx = lp ? tx : pat;
    exp_cs = ~(4'b0001 << cs);
    ecnt   = 0;
    mcap   = 8'h00;
    pat_sh = pat;
    psclk  = md[1];
    @(negedge clk);
    bus.clk_div = div;
    bus.mode    = md;
    bus.cs_sel  = cs;
    bus.tx_data = tx;
    bus.irq_en  = ien;
    loop_en     = lp;
    miso_drv    = pat_sh[7];
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= last + 3; cyc++) begin
      cur_cyc = cyc;
      if (cyc == last && ien) irq_cur = 1'b1;
      if (cyc == last + 1 && clr_at_done && !ien) irq_cur = 1'b0;
      n_exp = (cyc <= h) ? 0 : (cyc - h - 1) / h + 1;
      if (n_exp > 16) n_exp = 16;
      exp_sclk = (cyc <= last) ? (md[1] ^ n_exp[0]) : bus.mode[1];
      chk1("busy", bus.busy, cyc < last);
      chk1("done", bus.done, cyc == last);
      chk4("cs_n", bus.cs_n, (cyc < last) ? exp_cs : 4'hF);
      chk1("sclk", bus.sclk, exp_sclk);
      chk8("rx_data", bus.rx_data, (cyc < last) ? prev_rx : exp_rx);
      chk1("irq", bus.irq, irq_cur);
      if (cyc > last) chk1("mosi_idle", bus.mosi, 1'b0);
      if (cyc <= last && bus.sclk !== psclk) begin
        ecnt++;
        samp_edge = md[0] ? (ecnt % 2 == 0) : (ecnt % 2 == 1);
        if (samp_edge) begin
          mcap     = {mcap[6:0], bus.mosi};
          pat_sh   = {pat_sh[6:0], 1'b0};
          miso_drv = pat_sh[7];
        end
      end
      psclk = bus.sclk;
      if (disturb && cyc == 5) begin
        bus.start   = 1'b1;
        bus.clk_div = 3'($urandom);
        bus.mode    = 2'($urandom);
        bus.cs_sel  = cs + 2'd1;
        bus.tx_data = ~tx;
        bus.irq_en  = ~ien;
      end
      if (disturb && cyc == 6) bus.start = 1'b0;
      if (clr_at_done && cyc == last) bus.irq_clr = 1'b1;
      if (cyc == last + 1) bus.irq_clr = 1'b0;
      @(negedge clk);
    end
    chk8("sclk_edges", 8'(ecnt), 8'd16);
    chk8("mosi_stream", mcap, tx);
    prev_rx = exp_rx;
  endtask

  initial begin
    rst         = 1'b0;
    loop_en     = 1'b0;
    miso_drv    = 1'b0;
    bus.clk_div = 3'd0;
    bus.irq_en  = 1'b0;
    bus.cs_sel  = 2'd0;
    bus.mode    = 2'b11;
    bus.tx_data = 8'h00;
    bus.start   = 1'b0;
    bus.irq_clr = 1'b0;
    prev_rx     = 8'h00;
    irq_cur     = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_irq", bus.irq, 1'b0);
    chk8("rst_rx", bus.rx_data, 8'h00);
    chk1("rst_mosi", bus.mosi, 1'b0);
    chk4("rst_cs_n", bus.cs_n, 4'hF);
    chk1("rst_sclk", bus.sclk, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("sclk_live_cpol", bus.sclk, 1'b1);

    run_xfer(3'd0, 2'd0, 2'd2, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    run_xfer(3'd2, 2'd3, 2'($urandom), 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    run_xfer(3'd1, 2'd1, 2'd1, 8'($urandom), 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    run_xfer(3'd0, 2'd2, 2'd3, 8'($urandom), 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    run_xfer(3'd1, 2'd0, 2'd0, 8'($urandom), 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    bus.irq_clr = 1'b1;
    @(negedge clk);
    bus.irq_clr = 1'b0;
    irq_cur     = 1'b0;
    chk1("irq_lone_clr", bus.irq, 1'b0);

    // Asynchronous reset in the middle of a clk_div=3 transfer.
    bus.clk_div = 3'd3;
    bus.mode    = 2'b10;
    bus.cs_sel  = 2'd1;
    bus.tx_data = 8'h96;
    bus.irq_en  = 1'b1;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    chk1("pre_rst_busy", bus.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk4("mid_rst_cs_n", bus.cs_n, 4'hF);
    chk1("mid_rst_busy", bus.busy, 1'b0);
    chk1("mid_rst_sclk", bus.sclk, 1'b0);
    chk1("mid_rst_mosi", bus.mosi, 1'b0);
    chk1("mid_rst_done", bus.done, 1'b0);
    prev_rx = 8'h00;
    irq_cur = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cur_cyc = i;
      chk1("post_rst_done", bus.done, 1'b0);
      chk1("post_rst_busy", bus.busy, 1'b0);
      chk1("post_rst_sclk", bus.sclk, 1'b1);
    end
    run_xfer(3'd3, 2'd2, 2'd1, 8'h96, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      run_xfer(3'($urandom_range(3, 0)), 2'($urandom), 2'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'($urandom));
    end

    run_xfer(3'd7, 2'd1, 2'($urandom), 8'($urandom), 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
